mem_rr_arbiter: RTL and testbench

// Round-robin arbiter and sequencer sharing one WORD_SIZE-wide register memory

---
 rtl/mem_rr_arbiter_if.sv | 35 +++
 rtl/mem_rr_arbiter.sv | 88 ++++++++
 tb/tb_mem_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the two requester ports and the shared read-return path of mem_rr_arbiter.
// state_dbg mirrors the arbiter FSM register so checkers can bind to it.
interface mem_rr_arbiter_if #(
  parameter int WORD_SIZE = 4,
  parameter int ADDR_W    = 2
);
  // Handshake: a requester raises reqN (level) with weN/addrN/wdataN and holds
  // them until gntN is high; the gnt cycle is the access cycle. Keeping reqN
  // high through the gnt cycle asks for another access, dropping it ends it.
  logic                 req0;
  logic                 we0;
  logic [ADDR_W-1:0]    addr0;
  logic [WORD_SIZE-1:0] wdata0;
  logic                 req1;
  logic                 we1;
  logic [ADDR_W-1:0]    addr1;
  logic [WORD_SIZE-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rvalid;
  logic                 rid;
  logic                 busy;
  logic [1:0]           state_dbg;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, gnt1, rdata, rvalid, rid, busy, state_dbg
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, gnt1, rdata, rvalid, rid, busy, state_dbg
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter giving two requesters one access per cycle to a shared
// word register file; all outputs come straight from flops.
module mem_rr_arbiter #(
  parameter int WORD_SIZE = 4,
  parameter int ADDR_W    = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_rr_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 last;
  logic                 gnt0_q;
  logic                 gnt1_q;
  logic                 busy_q;
  logic                 rvalid_q;
  logic                 rid_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Under contention the port that was not served most recently wins.
  always_comb begin
    state_nxt = IDLE;
    if (bus.req0 && bus.req1) state_nxt = last ? SERVE0 : SERVE1;
    else if (bus.req0)        state_nxt = SERVE0;
    else if (bus.req1)        state_nxt = SERVE1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      rdata_q  <= '0;
      mem      <= '{default: '0};
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        SERVE0: begin
          if (bus.we0) begin
            mem[bus.addr0] <= bus.wdata0;
          end else begin
            rdata_q  <= mem[bus.addr0];
            rid_q    <= 1'b0;
            rvalid_q <= 1'b1;
          end
        end
        SERVE1: begin
          if (bus.we1) begin
            mem[bus.addr1] <= bus.wdata1;
          end else begin
            rdata_q  <= mem[bus.addr1];
            rid_q    <= 1'b1;
            rvalid_q <= 1'b1;
          end
        end
        default: ;
      endcase
      state  <= state_nxt;
      gnt0_q <= (state_nxt == SERVE0);
      gnt1_q <= (state_nxt == SERVE1);
      busy_q <= (state_nxt != IDLE);
      if (state_nxt == SERVE0) last <= 1'b0;
      if (state_nxt == SERVE1) last <= 1'b1;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.busy      = busy_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rid       = rid_q;
  assign bus.rdata     = rdata_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of the shared memory.
module tb_mem_rr_arbiter;
  localparam int W = 4;
  localparam int A = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.WORD_SIZE(W), .ADDR_W(A)) bus ();
  mem_rr_arbiter #(.WORD_SIZE(W), .ADDR_W(A)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // requester shadow state
  logic         r_req  [2];
  logic         r_we   [2];
  logic [A-1:0] r_addr [2];
  logic [W-1:0] r_wd   [2];

  // behavioural model: who holds the memory this cycle, who was served last
  int           m_owner;
  int           m_last;
  logic [W-1:0] m_mem [4];
  logic         m_rvalid;
  logic         m_rid;
  logic [W-1:0] m_rdata;
  logic [W:0]   exp_q[$];
  int           gnt_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    bus.req0 = r_req[0]; bus.we0 = r_we[0]; bus.addr0 = r_addr[0]; bus.wdata0 = r_wd[0];
    bus.req1 = r_req[1]; bus.we1 = r_we[1]; bus.addr1 = r_addr[1]; bus.wdata1 = r_wd[1];
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [A-1:0] addr, input logic [W-1:0] wd);
    r_req[p] = req; r_we[p] = we; r_addr[p] = addr; r_wd[p] = wd;
    apply();
  endtask

  task automatic model_access(input int p);
    if (r_we[p]) begin
      m_mem[r_addr[p]] = r_wd[p];
    end else begin
      m_rvalid = 1'b1;
      m_rid    = (p == 1);
      m_rdata  = m_mem[r_addr[p]];
      exp_q.push_back({m_rid, m_rdata});
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_owner = -1; m_last = 1; m_rvalid = 1'b0; m_rid = 1'b0; m_rdata = '0;
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
      exp_q.delete();
      return;
    end
    m_rvalid = 1'b0;
    if (m_owner >= 0) model_access(m_owner);
    if (r_req[0] && r_req[1]) m_owner = 1 - m_last;
    else if (r_req[0])        m_owner = 0;
    else if (r_req[1])        m_owner = 1;
    else                      m_owner = -1;
    if (m_owner >= 0) m_last = m_owner;
  endtask

  task automatic compare_outputs();
    logic [W:0] e;
    check("gnt0", bus.gnt0, m_owner == 0);
    check("gnt1", bus.gnt1, m_owner == 1);
    check("busy", bus.busy, m_owner != -1);
    check("state_idle", bus.state_dbg == 2'd0, m_owner == -1);
    check("rvalid", bus.rvalid, m_rvalid);
    check("rdata_hold", bus.rdata, m_rdata);
    if (bus.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("read_rid", bus.rid, e[W]);
        check("read_data", bus.rdata, e[W-1:0]);
      end
    end
    gnt_log.push_back(bus.gnt0 ? 0 : (bus.gnt1 ? 1 : 2));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic apply_reset();
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // One access on port p: request, wait for the grant (bounded), drop req.
  task automatic single_access(input int p, input logic we, input logic [A-1:0] addr,
                               input logic [W-1:0] wd);
    int waited = 0;
    set_port(p, 1'b1, we, addr, wd);
    cycle();
    while (m_owner != p && waited < 4) begin
      cycle();
      waited++;
    end
    check("grant_wait", m_owner == p, 1);
    check("grant_seen", p == 0 ? bus.gnt0 : bus.gnt1, 1);
    r_req[p] = 1'b0;
    apply();
    cycle();
  endtask

  task automatic random_traffic(input int n);
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (m_owner == p) begin
          r_req[p] = 1'($urandom_range(0, 1));
        end else if (!r_req[p] && $urandom_range(0, 1) == 1) begin
          r_req[p]  = 1'b1;
          r_we[p]   = 1'($urandom_range(0, 1));
          r_addr[p] = A'($urandom_range(0, 3));
          r_wd[p]   = W'($urandom_range(0, 15));
        end
      end
      apply();
      cycle();
    end
    for (int p = 0; p < 2; p++) r_req[p] = 1'b0;
    apply();
    cycle();
    cycle();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, '0);
    model_edge();
    apply_reset();

    // T1: reset after random traffic clears outputs and memory
    random_traffic(200);
    r_req[0] = 1'b1; r_req[1] = 1'b1; apply();
    cycle();
    apply_reset();
    check("t1_gnt0", bus.gnt0, 0);
    check("t1_gnt1", bus.gnt1, 0);
    check("t1_rvalid", bus.rvalid, 0);
    check("t1_rdata", bus.rdata, 0);
    check("t1_rid", bus.rid, 0);
    check("t1_busy", bus.busy, 0);
    for (int a = 0; a < 4; a++) begin
      single_access(0, 1'b0, A'(a), '0);
      check("t1_read_zero", bus.rdata, 0);
    end

    // T2: single write then read back on port 0
    apply_reset();
    single_access(0, 1'b1, 2'd2, 4'hA);
    check("t2_wr_rvalid", bus.rvalid, 0);
    single_access(0, 1'b0, 2'd2, 4'h0);
    check("t2_rvalid", bus.rvalid, 1);
    check("t2_rdata", bus.rdata, 4'hA);
    check("t2_rid", bus.rid, 0);

    // T3: both held 6 cycles -> 0,1,0,1,0,1
    apply_reset();
    gnt_log.delete();
    set_port(0, 1'b1, 1'b0, 2'd1, '0);
    set_port(1, 1'b1, 1'b0, 2'd2, '0);
    for (int c = 0; c < 6; c++) cycle();
    for (int c = 0; c < 6; c++) check("t3_gnt_seq", gnt_log[c], c % 2);
    set_port(0, 1'b0, 1'b0, 2'd1, '0);
    set_port(1, 1'b0, 1'b0, 2'd2, '0);
    cycle();
    cycle();

    // T4: back-to-back writes on port 1, then read back
    apply_reset();
    gnt_log.delete();
    set_port(1, 1'b1, 1'b1, 2'd0, 4'd1);
    cycle();
    cycle();
    set_port(1, 1'b1, 1'b1, 2'd1, 4'd2);
    cycle();
    set_port(1, 1'b1, 1'b1, 2'd2, 4'd3);
    cycle();
    set_port(1, 1'b0, 1'b1, 2'd3, 4'd4);
    cycle();
    for (int c = 0; c < 4; c++) check("t4_gnt1_run", gnt_log[c], 1);
    check("t4_idle_after", gnt_log[4], 2);
    for (int a = 0; a < 4; a++) begin
      single_access(1, 1'b0, A'(a), '0);
      check("t4_read", bus.rdata, a + 1);
    end

    // T5: reset during the grant cycle of a write cancels it
    apply_reset();
    set_port(0, 1'b1, 1'b1, 2'd1, 4'hF);
    cycle();
    check("t5_gnt0", bus.gnt0, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_port(0, 1'b0, 1'b1, 2'd1, 4'hF);
    check("t5_gnt0_off", bus.gnt0, 0);
    check("t5_idle", bus.state_dbg, 0);
    single_access(0, 1'b0, 2'd1, '0);
    check("t5_mem1", bus.rdata, 0);

    // T6: port 0 writes addr 3, port 1 reads it on the next grant
    apply_reset();
    set_port(0, 1'b1, 1'b1, 2'd3, 4'h5);
    set_port(1, 1'b1, 1'b0, 2'd3, 4'h0);
    cycle();
    check("t6_gnt0", bus.gnt0, 1);
    set_port(0, 1'b0, 1'b1, 2'd3, 4'h5);
    cycle();
    check("t6_gnt1", bus.gnt1, 1);
    set_port(1, 1'b0, 1'b0, 2'd3, 4'h0);
    cycle();
    check("t6_rvalid", bus.rvalid, 1);
    check("t6_rdata", bus.rdata, 4'h5);
    check("t6_rid", bus.rid, 1);

    // long random soak against the model
    random_traffic(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
